// File: rtl/alu.sv
// RV32I integer ALU for OP and OP-IMM instructions.
// Result is registered: one clock of latency, cleared asynchronously by rst (active-low).
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        is_imm,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic [31:0] out
);

    logic [31:0] out_d;
    logic [31:0] out_q;
    logic [4:0]  shamt;
    logic        alt;
    logic        unused_funct7;

    assign shamt = in2[4:0];
    assign alt   = funct7[5];

    // Only funct7[5] selects SUB/SRA; the remaining bits are don't-care.
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        out_d = '0;
        unique case (funct3)
            3'b000: begin
                if (!is_imm && alt) begin
                    out_d = in1 - in2;
                end else begin
                    out_d = in1 + in2;
                end
            end
            3'b001: out_d = in1 << shamt;
            3'b010: out_d = {31'b0, $signed(in1) < $signed(in2)};
            3'b011: out_d = {31'b0, in1 < in2};
            3'b100: out_d = in1 ^ in2;
            3'b101: begin
                // imm[10] aliases funct7[5], so SRAI needs no is_imm term.
                if (alt) begin
                    out_d = $signed(in1) >>> shamt;
                end else begin
                    out_d = in1 >> shamt;
                end
            end
            3'b110: out_d = in1 | in2;
            3'b111: out_d = in1 & in2;
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus random stimulus
// against a behavioural reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        is_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] out;

    int checks;
    int errors;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .in1    (in1),
        .in2    (in2),
        .is_imm (is_imm),
        .funct3 (funct3),
        .funct7 (funct7),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic imm,
                                            input logic [2:0] f3,
                                            input logic [6:0] f7);
        logic [31:0] r;
        int sh;
        sh = int'(b % 32);
        r = a;
        case (f3)
            3'd0: r = (!imm && f7[5]) ? a - b : a + b;
            3'd1: repeat (sh) r = r * 2;
            3'd2: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: repeat (sh) r = {(f7[5] ? r[31] : 1'b0), r[31:1]};
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic imm, input logic [2:0] f3,
                         input logic [6:0] f7);
        in1 = a;
        in2 = b;
        is_imm = imm;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic step(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic imm,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] exp);
        drive(a, b, imm, f3, f7);
        @(posedge clk);
        #1;
        check(tag, out, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        drive(32'd5, 32'd7, 1'b0, 3'b000, 7'd0);
        #2;
        check("reset_async", out, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", out, 32'd12);

        step("sub", 32'd3, 32'd5, 1'b0, 3'b000, 7'b0100000, 32'hFFFFFFFE);
        step("addi_f7", 32'd3, 32'd5, 1'b1, 3'b000, 7'b0100000, 32'd8);
        step("srl", 32'h80000000, 32'd4, 1'b0, 3'b101, 7'd0, 32'h08000000);
        step("sra", 32'h80000000, 32'd4, 1'b0, 3'b101, 7'b0100000, 32'hF8000000);
        step("srli", 32'h80000000, 32'd4, 1'b1, 3'b101, 7'd0, 32'h08000000);
        step("srai", 32'h80000000, 32'd4, 1'b1, 3'b101, 7'b0100000, 32'hF8000000);
        step("slt_neg", 32'hFFFFFFFF, 32'd1, 1'b0, 3'b010, 7'd0, 32'd1);
        step("sltu_neg", 32'hFFFFFFFF, 32'd1, 1'b0, 3'b011, 7'd0, 32'd0);
        step("slt_eq", 32'd7, 32'd7, 1'b0, 3'b010, 7'd0, 32'd0);
        step("sltu_eq", 32'd7, 32'd7, 1'b0, 3'b011, 7'd0, 32'd0);
        step("sll_hi", 32'd1, 32'hFFFFFFE1, 1'b0, 3'b001, 7'd0, 32'd2);
        step("xor", 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 3'b100, 7'd0, 32'h0FF00FF0);
        step("or", 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 3'b110, 7'd0, 32'hFFF0FFF0);
        step("and", 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 3'b111, 7'd0, 32'hF000F000);
        step("sll0", 32'h12345678, 32'd0, 1'b0, 3'b001, 7'd0, 32'h12345678);
        step("sra31", 32'h80000000, 32'd31, 1'b0, 3'b101, 7'b0100000, 32'hFFFFFFFF);
        step("srl31", 32'h80000000, 32'd31, 1'b0, 3'b101, 7'd0, 32'h00000001);
        step("sll31", 32'h00000003, 32'd31, 1'b0, 3'b001, 7'd0, 32'h80000000);
        step("add_f7junk", 32'hFFFFFFFF, 32'd1, 1'b0, 3'b000, 7'b1011111, 32'h0);

        // Inputs changed mid-cycle must not reach out before the edge.
        drive(32'd100, 32'd1, 1'b0, 3'b000, 7'd0);
        #2;
        check("no_early", out, 32'h0);
        @(posedge clk);
        #1;
        check("edge_update", out, 32'd101);
        step("hold", 32'd100, 32'd1, 1'b0, 3'b000, 7'd0, 32'd101);

        #2;
        rst = 1'b0;
        #1;
        check("rst_mid", out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_recover", out, 32'd101);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        imm;
            logic [2:0]  f3;
            logic [6:0]  f7;
            a = $urandom;
            b = $urandom;
            imm = 1'($urandom);
            f3 = 3'($urandom);
            f7 = 7'($urandom);
            if (i % 4 == 0) b = b & 32'h1F;
            if (i % 8 == 1) b = a;
            step("rand", a, b, imm, f3, f7, ref_alu(a, b, imm, f3, f7));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
